imm_ext_stage: RTL and testbench
================================

# imm_ext_stage

Registered, parametrised immediate-extension stage for the MIPS 6-stage pipeline, sitting between decode and the execute operand mux. It widens an IN_W-bit immediate to OUT_W bits in one of several modes: sign-extend, zero-extend, upper-load, and optionally branch-offset. Each result carries a tag through a valid/ready handshake, and a 2-entry skid buffer absorbs back-pressure from execute without a combinational ready path. Flush support discards in-flight immediates on branch mispredict.

## Interface
Parameters:
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + 2
- TAG_W, 5, sideband tag width (destination register / slot id), passed unmodified

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming entries this cycle
- in_valid  in  1  input entry present
- in_ready  out  1  stage can accept; driven from flop state only
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  00 SEXT, 01 ZEXT, 10 LUI, 11 BOFF
- in_tag  in  TAG_W  sideband
- out_valid  out  1  output entry present
- out_ready  in  1  execute accepts
- out_imm  out  OUT_W  extended immediate
- out_tag  out  TAG_W  tag of out_imm

## Operation
Extension rules (combinational on the input, then registered):
- SEXT: {(OUT_W-IN_W){in_imm[IN_W-1]}, in_imm}
- ZEXT: {(OUT_W-IN_W){1'b0}, in_imm}
- LUI: in_imm placed in the top IN_W bits, low OUT_W-IN_W bits zero
- BOFF: SEXT result shifted left 2, low 2 bits zero, top bits truncated

Handshake and buffering:
- Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- Storage is a main register (drives outputs) plus one skid register. States: EMPTY (0 held), ONE (main valid), FULL (main + skid valid).
- EMPTY + accept -> ONE.
- ONE + accept, no transfer -> FULL (new entry to skid).
- ONE + accept + transfer -> ONE (new entry to main).
- ONE + transfer only -> EMPTY.
- FULL + transfer -> ONE (skid moves to main). No accept is possible in FULL.
- in_ready = (state != FULL) && !rst.
- Ordering is strictly FIFO; entries are never dropped or duplicated.
- flush: next state EMPTY. Any accept and transfer in the same cycle are ignored for storage purposes. out_imm/out_tag keep stale values and are don't-care while out_valid=0.
- Priority is rst > flush > normal.

## Timing
- Reset values: out_valid=0, out_imm=0, out_tag=0, state EMPTY, skid contents 0. in_ready=0 during rst and 1 the first cycle after.
- Latency: accept at edge N gives out_valid=1 with the result after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready falls the cycle after the stage enters FULL and rises the cycle after the first transfer out of FULL.
- Reset or flush asserted mid-stream: empty after that edge; the next accepted entry follows normal latency.

## Configuration
- IMM_EXT_BOFF_EN defined: mode 11 performs BOFF as specified.
- Undefined: mode 11 decodes as SEXT, and no shifter logic is synthesised.

## Structure
- Shared package imm_ext_pkg holds the mode enum (IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BOFF) and the 2-bit mode width constant, for reuse by the decoder.
- One sub-module, imm_ext_fn: purely combinational extension function (IN_W, OUT_W, mode -> value). The top level holds the skid FSM and registers.

## Test plan
- SEXT 16'h8004, out_ready=1 -> next cycle out_imm=32'hFFFF8004, out_valid=1; ZEXT 16'h8004 -> 32'h00008004.
- LUI 16'h1234 -> 32'h12340000; BOFF 16'hFFFF with macro -> 32'hFFFFFFFC, without macro -> 32'hFFFFFFFF.
- Back-pressure: out_ready=0, send tags 1,2 -> in_ready=0 after the second accept; release out_ready -> tags 1 then 2 in consecutive cycles, in_ready=1 again.
- Stream 8 entries with out_ready toggling every cycle -> all 8 emerge in order, none lost or duplicated.
- flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle input never appears.
- rst asserted in ONE -> next cycle out_valid=0, out_imm=0, in_ready=0; after rst deasserts, in_ready=1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared definitions for the immediate-extension stage and the decoder that
// drives it: the 2-bit extension-mode encoding and the skid-buffer states.
package imm_ext_pkg;

   localparam int IMM_MODE_W = 2;

   typedef enum logic [IMM_MODE_W-1:0] {
      IMM_SEXT = 2'b00,
      IMM_ZEXT = 2'b01,
      IMM_LUI  = 2'b10,
      IMM_BOFF = 2'b11
   } imm_mode_e;

   // Occupancy of the main + skid register pair.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } skid_state_e;

endpackage

// File: rtl/imm_ext_stage_if.sv
// imm_ext_stage_if
// Decode-to-execute immediate bus: input valid/ready handshake carrying the
// raw immediate, mode and tag, and output valid/ready handshake carrying the
// extended immediate and tag.
//   master : decode/execute side (drives in_*, out_ready)
//   slave  : imm_ext_stage (drives in_ready, out_*)
interface imm_ext_stage_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
);
   import imm_ext_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [IN_W-1:0]       in_imm;
   logic [IMM_MODE_W-1:0] in_mode;
   logic [TAG_W-1:0]      in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_W-1:0]      out_imm;
   logic [TAG_W-1:0]      out_tag;

   modport master (
      output in_valid, in_imm, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag
   );

   modport slave (
      input  in_valid, in_imm, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag
   );
endinterface

// File: rtl/imm_ext_fn.sv
// imm_ext_fn
// Purely combinational immediate extension IN_W -> OUT_W.
//   i_imm   : raw immediate
//   i_mode  : SEXT / ZEXT / LUI / BOFF
//   o_value : extended immediate
// Optional feature macro: IMM_EXT_BOFF_EN. When undefined, mode BOFF decodes
// as SEXT and the shifted-offset path does not exist. OUT_W must be at least
// IN_W + 2 so the branch offset keeps the full shifted immediate.
module imm_ext_fn
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_imm,
   input  imm_mode_e        i_mode,
   output logic [OUT_W-1:0] o_value
);

   logic [OUT_W-1:0] w_sext;
   assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

   always_comb begin
      o_value = w_sext;
      case (i_mode)
         IMM_ZEXT: o_value = {{(OUT_W-IN_W){1'b0}}, i_imm};
         IMM_LUI:  o_value = {i_imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BOFF_EN
         // Word-aligned branch offset: top two sign bits fall off.
         IMM_BOFF: o_value = {w_sext[OUT_W-3:0], 2'b00};
`endif
         default:  o_value = w_sext;
      endcase
   end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// Registered immediate-extension stage between decode and the execute
// operand mux, with a 2-entry skid buffer so in_ready comes from flops only.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears state and data registers)
//   flush : discards all held and incoming entries this cycle
//   bus   : imm_ext_stage_if.slave (in_* accept side, out_* execute side)
// Optional feature macro: IMM_EXT_BOFF_EN (enables branch-offset mode in
// imm_ext_fn).
module imm_ext_stage
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   imm_ext_stage_if.slave  bus
);

   logic [OUT_W-1:0] w_ext;
   logic             w_acc;
   logic             w_xfer;

   skid_state_e      r_state;
   logic [OUT_W-1:0] r_main_imm;
   logic [TAG_W-1:0] r_main_tag;
   logic [OUT_W-1:0] r_skid_imm;
   logic [TAG_W-1:0] r_skid_tag;

   imm_ext_fn #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_fn (
      .i_imm   (bus.in_imm),
      .i_mode  (imm_mode_e'(bus.in_mode)),
      .o_value (w_ext)
   );

   // Ready depends only on the occupancy flop (and reset), never on out_ready.
   assign bus.in_ready  = (r_state != ST_FULL) && !rst;
   assign bus.out_valid = (r_state != ST_EMPTY);
   assign bus.out_imm   = r_main_imm;
   assign bus.out_tag   = r_main_tag;

   assign w_acc  = bus.in_valid && bus.in_ready;
   assign w_xfer = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_main_imm <= '0;
         r_main_tag <= '0;
         r_skid_imm <= '0;
         r_skid_tag <= '0;
      end else if (flush) begin
         // Data registers keep stale values; out_valid=0 masks them.
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  r_main_imm <= w_ext;
                  r_main_tag <= bus.in_tag;
                  r_state    <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_acc && w_xfer) begin
                  r_main_imm <= w_ext;
                  r_main_tag <= bus.in_tag;
               end else if (w_acc) begin
                  r_skid_imm <= w_ext;
                  r_skid_tag <= bus.in_tag;
                  r_state    <= ST_FULL;
               end else if (w_xfer) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a transfer can happen.
               if (w_xfer) begin
                  r_main_imm <= r_skid_imm;
                  r_main_tag <= r_skid_tag;
                  r_state    <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;
   import imm_ext_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   imm_ext_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

   imm_ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag);
      bus.in_valid = v;
      bus.in_imm   = imm;
      bus.in_mode  = mode;
      bus.in_tag   = tag;
   endtask

   logic [4:0] expq[$];
   logic [4:0] e_tag;
   logic [31:0] boff_exp;
   int sent;
   int got;

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      tick();
      tick();
      // Reset state
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_imm", bus.out_imm, 32'h0);
      chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Extension modes, back-to-back at full throughput
      drive(1'b1, 16'h8004, IMM_SEXT, 5'd3);
      tick();
      chk("sext_valid", 32'(bus.out_valid), 32'd1);
      chk("sext_imm", bus.out_imm, 32'hFFFF8004);
      chk("sext_tag", 32'(bus.out_tag), 32'd3);
      drive(1'b1, 16'h8004, IMM_ZEXT, 5'd4);
      tick();
      chk("zext_imm", bus.out_imm, 32'h00008004);
      chk("zext_tag", 32'(bus.out_tag), 32'd4);
      drive(1'b1, 16'h1234, IMM_LUI, 5'd5);
      tick();
      chk("lui_imm", bus.out_imm, 32'h12340000);
      drive(1'b1, 16'hFFFF, IMM_BOFF, 5'd6);
      tick();
`ifdef IMM_EXT_BOFF_EN
      boff_exp = 32'hFFFFFFFC;
`else
      boff_exp = 32'hFFFFFFFF;
`endif
      chk("boff_imm", bus.out_imm, boff_exp);
      chk("boff_tag", 32'(bus.out_tag), 32'd6);
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      tick();
      chk("drain_valid", 32'(bus.out_valid), 32'd0);

      // Back-pressure into FULL and release
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h0001, IMM_SEXT, 5'd1);
      tick();
      chk("bp_one_in_ready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 16'h0002, IMM_SEXT, 5'd2);
      tick();
      chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_full_tag", 32'(bus.out_tag), 32'd1);
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_rel_tag2", 32'(bus.out_tag), 32'd2);
      chk("bp_rel_imm2", bus.out_imm, 32'h00000002);
      chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("bp_empty", 32'(bus.out_valid), 32'd0);

      // Stream 8 entries with out_ready toggling every cycle
      sent = 0;
      got = 0;
      for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
         drive(sent < 8, 16'(sent * 16'h1111), IMM_ZEXT, 5'(8 + sent));
         bus.out_ready = (cyc % 2 == 0);
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               chk("stream_extra", 32'(bus.out_tag), 32'hFFFF);
            end else begin
               e_tag = expq.pop_front();
               chk("stream_tag", 32'(bus.out_tag), 32'(e_tag));
               chk("stream_imm", bus.out_imm, {16'h0, 16'((int'(e_tag) - 8) * 16'h1111)});
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back(5'(8 + sent));
            sent++;
         end
         tick();
      end
      chk("stream_count", 32'(got), 32'd8);
      chk("stream_sent", 32'(sent), 32'd8);
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("stream_drained", 32'(bus.out_valid), 32'd0);

      // Flush while FULL with an input presented
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h0014, IMM_SEXT, 5'd20);
      tick();
      drive(1'b1, 16'h0015, IMM_SEXT, 5'd21);
      tick();
      chk("fl_full_in_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 16'h0016, IMM_SEXT, 5'd22);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
      chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("fl_no_ghost", 32'(bus.out_valid), 32'd0);

      // Normal latency after flush, then reset while ONE
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h7FFF, IMM_SEXT, 5'd23);
      tick();
      chk("fl_next_valid", 32'(bus.out_valid), 32'd1);
      chk("fl_next_imm", bus.out_imm, 32'h00007FFF);
      chk("fl_next_tag", 32'(bus.out_tag), 32'd23);
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);
      rst = 1'b1;
      tick();
      chk("rst_one_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_one_imm", bus.out_imm, 32'h0);
      chk("rst_one_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_one_rel_ready", 32'(bus.in_ready), 32'd1);
      drive(1'b1, 16'hFFFF, IMM_LUI, 5'd25);
      tick();
      chk("post_rst_lui", bus.out_imm, 32'hFFFF0000);
      chk("post_rst_tag", 32'(bus.out_tag), 32'd25);
      drive(1'b0, 16'h0, IMM_SEXT, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
